// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor
//   Receive-side VGA timing checker. Watches an incoming active-low hsync/vsync
//   pair, recovers pixel/line position, measures line length and frame height,
//   and declares lock after LOCK_FRAMES consecutive good frames.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   SEARCH   | no frame boundary seen yet; waiting for the first one
//   MEASURE  | counting consecutive good frames toward lock
//   LOCKED   | timing matches; de / pix_x / pix_y are valid
//
// Ports
//   reloj        in   system clock
//   resetM       in   synchronous active-high reset
//   pix_en       in   pixel tick qualifier; all sampling and counting gated by it
//   hsync_in     in   horizontal sync, active low
//   vsync_in     in   vertical sync, active low
//   pix_x/pix_y  out  active pixel column/line, 0 outside active window or unlocked
//   de           out  data enable (locked and inside active window)
//   line_len     out  last measured line length in pixel ticks (saturating)
//   frame_lines  out  last measured frame height in lines (saturating)
//   frame_start  out  one-cycle pulse per recognised frame boundary
//   locked       out  high while in LOCKED
//   sync_err     out  one-cycle pulse on loss of lock (bad line/frame, watchdog)
module vga_sync_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_OFS       = 144,
    parameter int H_ACTIVE    = 640,
    parameter int V_OFS       = 35,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       reloj,
    input  logic       resetM,
    input  logic       pix_en,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       de,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err
);

    typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;

    localparam logic [9:0] CNT_MAX   = 10'd1023;
    localparam logic [9:0] H_TOTAL_W = 10'(H_TOTAL);
    localparam logic [9:0] V_TOTAL_W = 10'(V_TOTAL);
    localparam logic [9:0] H_OFS_W   = 10'(H_OFS);
    localparam logic [9:0] H_END_W   = 10'(H_OFS + H_ACTIVE);
    localparam logic [9:0] V_OFS_W   = 10'(V_OFS);
    localparam logic [9:0] V_END_W   = 10'(V_OFS + V_ACTIVE);
    localparam logic [2:0] LOCK_W    = 3'(LOCK_FRAMES);

    state_t     state_q, state_d;
    logic       hs_q, hs_d, vs_q, vs_d;
    logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [9:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
    logic       meas_en_q, meas_en_d;
    logic       frame_bad_q, frame_bad_d;
    logic       pend_q, pend_d;
    logic [2:0] good_cnt_q, good_cnt_d;
    logic       frame_start_q, frame_start_d;
    logic       sync_err_q, sync_err_d;
    logic       de_q, de_d;
    logic [9:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;

    logic       hs_fall, vs_fall, boundary, bad_line, good_frame, in_win;
    logic [9:0] h_inc, v_inc;

    always_comb begin
        state_d       = state_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        meas_en_d     = meas_en_q;
        frame_bad_d   = frame_bad_q;
        pend_d        = pend_q;
        good_cnt_d    = good_cnt_q;
        frame_start_d = 1'b0;
        sync_err_d    = 1'b0;
        hs_fall       = 1'b0;
        vs_fall       = 1'b0;
        boundary      = 1'b0;
        bad_line      = 1'b0;
        good_frame    = 1'b0;

        // Saturating increments double as the "count + 1" measurements.
        h_inc = (h_cnt_q == CNT_MAX) ? CNT_MAX : h_cnt_q + 10'd1;
        v_inc = (v_cnt_q == CNT_MAX) ? CNT_MAX : v_cnt_q + 10'd1;

        // Output stage looks at the registered counters, so it trails them by one cycle.
        in_win  = (state_q == ST_LOCKED) &&
                  (h_cnt_q >= H_OFS_W) && (h_cnt_q < H_END_W) &&
                  (v_cnt_q >= V_OFS_W) && (v_cnt_q < V_END_W);
        de_d    = in_win;
        pix_x_d = in_win ? h_cnt_q - H_OFS_W : 10'd0;
        pix_y_d = in_win ? v_cnt_q - V_OFS_W : 10'd0;

        if (pix_en) begin
            hs_fall  = hs_q & ~hsync_in;
            vs_fall  = vs_q & ~vsync_in;
            hs_d     = hsync_in;
            vs_d     = vsync_in;
            boundary = hs_fall & (pend_q | vs_fall);
            h_cnt_d  = hs_fall ? 10'd0 : h_inc;

            if (hs_fall) begin
                // The first hsync after (re)start only opens a line; there is nothing to measure.
                meas_en_d = 1'b1;
                if (meas_en_q) begin
                    line_len_d = h_inc;
                    bad_line   = (h_inc != H_TOTAL_W);
                end
                if (boundary) begin
                    // The line closed by this hsync still belongs to the frame being judged.
                    good_frame    = (v_inc == V_TOTAL_W) && !frame_bad_q && !bad_line;
                    frame_lines_d = v_inc;
                    v_cnt_d       = 10'd0;
                    pend_d        = 1'b0;
                    frame_bad_d   = 1'b0;
                    frame_start_d = 1'b1;
                end else begin
                    v_cnt_d     = v_inc;
                    frame_bad_d = frame_bad_q | bad_line;
                end
            end
            if (vs_fall && !boundary) begin
                pend_d = 1'b1;
            end

            unique case (state_q)
                ST_SEARCH: begin
                    if (boundary) begin
                        state_d    = ST_MEASURE;
                        good_cnt_d = 3'd0;
                    end
                end
                ST_MEASURE: begin
                    if (boundary) begin
                        if (good_frame) begin
                            good_cnt_d = good_cnt_q + 3'd1;
                            if (good_cnt_q + 3'd1 == LOCK_W) begin
                                state_d = ST_LOCKED;
                            end
                        end else begin
                            good_cnt_d = 3'd0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (bad_line || (boundary && !good_frame)) begin
                        state_d    = ST_MEASURE;
                        good_cnt_d = 3'd0;
                        sync_err_d = 1'b1;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase

            // Watchdog: fires once, on the tick h_cnt saturates without an hsync.
            if (!hs_fall && (h_cnt_q == CNT_MAX - 10'd1)) begin
                state_d    = ST_SEARCH;
                good_cnt_d = 3'd0;
                meas_en_d  = 1'b0;
                sync_err_d = (state_q == ST_LOCKED);
            end
        end
    end

    always_ff @(posedge reloj) begin
        if (resetM) begin
            state_q       <= ST_SEARCH;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            line_len_q    <= 10'd0;
            frame_lines_q <= 10'd0;
            meas_en_q     <= 1'b0;
            frame_bad_q   <= 1'b0;
            pend_q        <= 1'b0;
            good_cnt_q    <= 3'd0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
            de_q          <= 1'b0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 10'd0;
        end else begin
            state_q       <= state_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            meas_en_q     <= meas_en_d;
            frame_bad_q   <= frame_bad_d;
            pend_q        <= pend_d;
            good_cnt_q    <= good_cnt_d;
            frame_start_q <= frame_start_d;
            sync_err_q    <= sync_err_d;
            de_q          <= de_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
        end
    end

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign de          = de_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign frame_start = frame_start_q;
    assign sync_err    = sync_err_q;
    assign locked      = (state_q == ST_LOCKED);

endmodule
